// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - byte transmitter: valid/ready in, start/data/stop serial frame out
// Define UART_TX_PARITY_EN to insert an even-parity bit after the MSB.
module uart_tx #(
    parameter int BYTESIZES   = 8,
    parameter int BAUDRATE    = 115200,
    parameter int CLOCK_INPUT = 50_000_000,
    parameter int STOPBITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BYTESIZES-1:0] datain,
    input  logic                 valid,
    output logic                 ready,
    output logic                 sdata,
    output logic                 tx_done
);
    localparam int DIV = CLOCK_INPUT / BAUDRATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(BYTESIZES - 1);
    localparam logic          STOP_LAST = (STOPBITS == 2);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx: CLOCK_INPUT / BAUDRATE must be at least 2");
        end
        if (STOPBITS != 1 && STOPBITS != 2) begin : g_stop_check
            $error("uart_tx: STOPBITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [IW-1:0]        bit_idx, bit_idx_nxt;
    logic                 stop_idx, stop_idx_nxt;
    logic [BYTESIZES-1:0] shift_reg, shift_nxt;
    logic                 sdata_nxt;
    logic                 done_nxt;
    logic                 bit_end;
    logic                 handshake;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit, par_nxt;
`endif

    assign ready     = (state == IDLE) && !reset;
    assign handshake = valid && ready;
    assign bit_end   = (cnt == CNT_LAST);

    // sdata_nxt reflects the current state, so the line lags the state by one flop
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        shift_nxt    = shift_reg;
        sdata_nxt    = 1'b1;
        done_nxt     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt      = par_bit;
`endif
        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                    shift_nxt = datain;
`ifdef UART_TX_PARITY_EN
                    par_nxt   = ^datain;
`endif
                end
            end
            START: begin
                sdata_nxt = 1'b0;
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = '0;
                end
            end
            DATA: begin
                sdata_nxt = shift_reg[0];
                if (bit_end) begin
                    shift_nxt   = shift_reg >> 1;
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        stop_idx_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_nxt    = PARITY;
`else
                        state_nxt    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                sdata_nxt = par_bit;
                if (bit_end) begin
                    state_nxt    = STOP;
                    stop_idx_nxt = 1'b0;
                end
            end
`endif
            STOP: begin
                sdata_nxt = 1'b1;
                if (bit_end) begin
                    if (stop_idx == STOP_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift_reg <= '0;
            sdata     <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            stop_idx  <= stop_idx_nxt;
            shift_reg <= shift_nxt;
            sdata     <= sdata_nxt;
            tx_done   <= done_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit   <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (1 and 2 stop bits, DIV=16)
module tb_uart_tx;
    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] datain [2];
    logic [1:0] valid = '0;
    logic [1:0] ready, sdata, tx_done;
    logic [1:0] exp_ready, exp_sdata, exp_done;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int done_cnt [2] = '{0, 0};
    int last_done [2] = '{0, 0};

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Frame as bit slots in line order: start, data LSB first, optional parity, stop(s)
    function automatic logic [11:0] mk_frame(input logic [7:0] d);
        logic [11:0] f = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (PAR == 1) f[9] = ^d;
        return f;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int FLEN = DIV * (10 + PAR + g);
        logic        m_active = 1'b0;
        int          m_k = 0;
        logic [11:0] m_frame = '1;
        logic [3:0]  m_slot;

        uart_tx #(.BYTESIZES(8), .BAUDRATE(1), .CLOCK_INPUT(DIV), .STOPBITS(g + 1)) dut (
            .clock(clock), .reset(reset), .datain(datain[g]), .valid(valid[g]),
            .ready(ready[g]), .sdata(sdata[g]), .tx_done(tx_done[g])
        );

        // m_k = cycles since the accepting edge; the line shows slot (m_k-1)/DIV
        always @(posedge clock) begin
            if (reset) begin
                m_active <= 1'b0;
                m_k      <= 0;
            end else if (exp_ready[g] && valid[g]) begin
                m_active <= 1'b1;
                m_k      <= 0;
                m_frame  <= mk_frame(datain[g]);
            end else if (m_active && m_k <= FLEN) begin
                m_k <= m_k + 1;
            end
        end
        assign m_slot       = 4'((m_k - 1) / DIV);
        assign exp_ready[g] = !reset && (!m_active || m_k >= FLEN);
        assign exp_sdata[g] = (m_active && m_k >= 1 && m_k <= FLEN) ? m_frame[m_slot] : 1'b1;
        assign exp_done[g]  = m_active && (m_k == FLEN);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic at_neg();
        @(negedge clock);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("ch%0d sdata", g), 32'(sdata[g]), 32'(exp_sdata[g]));
            chk($sformatf("ch%0d ready", g), 32'(ready[g]), 32'(exp_ready[g]));
            chk($sformatf("ch%0d tx_done", g), 32'(tx_done[g]), 32'(exp_done[g]));
            if (tx_done[g] === 1'b1) begin
                done_cnt[g]++;
                last_done[g] = cyc;
            end
        end
    endtask

    task automatic step();
        at_neg();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int g, input logic [7:0] d, input bit hold, output int e0);
        int n = 0;
        datain[g] = d;
        valid[g]  = 1'b1;
        while (ready[g] !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("handshake wait", 32'(n < 1000), 32'd1);
        step();
        e0 = cyc;
        if (!hold) valid[g] = 1'b0;
    endtask

    // Line-side receiver: find the start edge, then sample each slot at its centre
    task automatic capture(input int g, output logic [11:0] bits, output int fall);
        int n = 0;
        bits = '1;
        at_neg();
        while (sdata[g] !== 1'b0 && n < 2000) begin
            at_neg();
            n++;
        end
        chk("start bit seen", 32'(n < 2000), 32'd1);
        fall = cyc;
        repeat (DIV / 2) at_neg();
        bits[0] = sdata[g];
        for (int i = 1; i < 10 + PAR + g; i++) begin
            repeat (DIV) at_neg();
            bits[i] = sdata[g];
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [11:0] b, b2;
        logic [7:0]  lb [4];
        int e0, e1, f1, f2, n, d0;
        logic hi;
        lb = '{8'h55, 8'hC3, 8'h00, 8'hFF};
        datain[0] = 8'h00;
        datain[1] = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        at_neg();
        chk("reset ready", 32'(ready[0]), 32'd0);
        chk("reset sdata", 32'(sdata[0]), 32'd1);
        chk("reset tx_done", 32'(tx_done[1]), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step();
        chk("idle ready", 32'(ready[0]), 32'd1);

        d0 = done_cnt[0];
        send(0, 8'hA5, 1'b0, e0);
        chk("A5 ready low", 32'(ready[0]), 32'd0);
        capture(0, b, f1);
        chk("A5 start latency", 32'(f1 - e0), 32'd1);
        chk("A5 slots 0-8", 32'(b[8:0]), 32'h14A);
        chk("A5 stop", 32'(b[9 + PAR]), 32'd1);
        repeat (20) step();
        chk("A5 tx_done count", 32'(done_cnt[0] - d0), 32'd1);
        chk("A5 tx_done time", 32'(last_done[0] - e0), 32'(160 + 16 * PAR));

        d0 = done_cnt[0];
        send(0, 8'h00, 1'b1, e0);
        datain[0] = 8'hFF;
        capture(0, b, f1);
        send(0, 8'hFF, 1'b0, e1);
        capture(0, b2, f2);
        repeat (20) step();
        chk("b2b first byte", 32'(b[8:1]), 32'h00);
        chk("b2b second byte", 32'(b2[8:1]), 32'hFF);
        chk("b2b handshake spacing", 32'(e1 - e0), 32'(161 + 16 * PAR));
        chk("b2b high gap", 32'(f2 - (f1 + DIV * (9 + PAR))), 32'd17);
        chk("b2b tx_done count", 32'(done_cnt[0] - d0), 32'd2);

        d0 = done_cnt[0];
        send(0, 8'h3C, 1'b0, e0);
        repeat (69) step();
        reset = 1'b1;
        step();
        at_neg();
        chk("reset mid-frame sdata", 32'(sdata[0]), 32'd1);
        @(posedge clock);
        #1;
        step();
        reset = 1'b0;
        at_neg();
        chk("ready after reset", 32'(ready[0]), 32'd1);
        @(posedge clock);
        #1;
        n = 0;
        repeat (200) begin
            step();
            if (sdata[0] !== 1'b1) n++;
        end
        chk("line idle after reset", 32'(n), 32'd0);
        chk("no tx_done after reset", 32'(done_cnt[0] - d0), 32'd0);
        send(0, 8'h81, 1'b0, e0);
        capture(0, b, f1);
        chk("post-reset byte", 32'(b[8:1]), 32'h81);

        d0 = done_cnt[1];
        send(1, 8'h01, 1'b0, e0);
        capture(1, b, f1);
        chk("2stop byte", 32'(b[8:1]), 32'h01);
        chk("2stop stop bits", 32'({b[10 + PAR], b[9 + PAR]}), 32'd3);
        repeat (30) step();
        chk("2stop tx_done time", 32'(last_done[1] - e0), 32'(176 + 16 * PAR));
        chk("2stop tx_done count", 32'(done_cnt[1] - d0), 32'd1);
        send(1, 8'h01, 1'b0, e0);
        repeat (145 + 16 * PAR) step();
        n = 0;
        hi = 1'b1;
        for (int i = 0; i < 100; i++) begin
            at_neg();
            n++;
            if (sdata[1] !== 1'b1) hi = 1'b0;
            if (tx_done[1] === 1'b1) break;
            @(posedge clock);
            #1;
        end
        @(posedge clock);
        #1;
        chk("2stop high cycles", 32'(n), 32'd32);
        chk("2stop stays high", 32'(hi), 32'd1);

        for (int i = 0; i < 4; i++) begin
            send(0, lb[i], 1'b0, e0);
            capture(0, b, f1);
            chk($sformatf("loopback %0h", lb[i]), 32'(b[8:1]), 32'(lb[i]));
        end

`ifdef UART_TX_PARITY_EN
        send(0, 8'h07, 1'b0, e0);
        capture(0, b, f1);
        chk("parity of 07", 32'(b[9]), 32'd1);
        repeat (20) step();
        chk("parity frame length", 32'(last_done[0] - e0), 32'd176);
        send(0, 8'h03, 1'b0, e0);
        capture(0, b, f1);
        chk("parity of 03", 32'(b[9]), 32'd0);
`endif
        repeat (20) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that forms the line-side source for the receive path: it accepts parallel bytes through a valid/ready handshake and drives them onto the serial line as start bit, data LSB first, optional parity, and stop bit(s). Its `sdata` output is the signal the UART receiver samples, so frame format and bit timing match the receiver's defaults. Bit timing comes from an internal divider running on the single system clock; no oversampling is used on transmit.

## Interface
- `BYTESIZES`, 8: data bits per frame.
- `BAUDRATE`, 115200: line bit rate.
- `CLOCK_INPUT`, 50_000_000: `clock` frequency in Hz.
- `STOPBITS`, 1: stop bits per frame, legal values 1 or 2.

Ports:
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `datain`  input  BYTESIZES  byte to transmit; sampled only on handshake.
- `valid`  input  1  `datain` is valid.
- `ready`  output  1  block accepts a byte this cycle.
- `sdata`  output  1  serial line; idle high; registered.
- `tx_done`  output  1  one-cycle pulse when a frame's final stop bit completes.

## Operation
- Bit period: DIV = CLOCK_INPUT / BAUDRATE, using integer floor. DIV < 2 is a parameter error and must be caught by an elaboration-time check.
- Internal bit counter: width $clog2(DIV). It counts 0..DIV-1, then wraps to 0 and advances the bit.
- Handshake: a byte is accepted on a rising edge where `valid && ready`.
  - `datain` is copied into a shift register at that edge.
  - Later changes on `datain` are ignored.
  - `valid` may drop without `ready`; this has no effect.
- `ready` = (state == IDLE) && !`reset`.
- State machine:
  - IDLE: `sdata` = 1. On handshake, go to START and clear the bit counter.
  - START: `sdata` = 0 for DIV cycles, then go to DATA with the bit index at 0.
  - DATA: `sdata` = shift_reg[0]. Each DIV cycles, shift right and increment the bit index. After bit BYTESIZES-1 completes, go to PARITY if the parity macro is defined, otherwise to STOP.
  - PARITY (only with macro): drive the parity bit for DIV cycles, then go to STOP.
  - STOP: `sdata` = 1 for DIV*STOPBITS cycles, then go to IDLE and pulse `tx_done`.
- `sdata` is a flop: the value for a state appears the cycle after entering that state.
- Reset values: state IDLE, `sdata` = 1, `ready` = 0 while `reset` is high, `tx_done` = 0, counters 0, shift register 0.
- Reset mid-frame: the frame is abandoned.
  - `sdata` = 1 from the edge after `reset` is sampled.
  - No `tx_done` pulse is generated.
  - After reset deasserts, the block is in IDLE with `ready` = 1.
- Unused state encodings must return to IDLE.

## Timing
- Frame length: N = 1 + BYTESIZES + P + STOPBITS bits, where P = 1 with parity and 0 without.
- Handshake at edge E0:
  - `sdata` falls after E0 + 1.
  - Each bit lasts exactly DIV cycles.
  - `sdata` is high for the final stop bit through E0 + 1 + DIV*N.
- Return to IDLE at edge E0 + DIV*N:
  - `tx_done` is high for the cycle after that edge.
  - `ready` is high from that cycle.
- Earliest next handshake is edge E0 + DIV*N + 1. Between back-to-back frames the line is high for DIV*STOPBITS + 1 cycles.
- A handshake cannot occur in the same cycle as `tx_done` unless `valid` is already high. In that case it is accepted in that cycle, since `ready` is high.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
  - Defined: an even-parity bit (XOR of all `datain` bits) is inserted after the MSB, and N includes it.
  - Undefined: the PARITY state and its logic are absent, and the frame is start + data + stop. This is the receiver-compatible default.

## Test plan
- Single byte: CLOCK_INPUT=16, BAUDRATE=1 (DIV=16), `datain`=8'hA5, one-cycle `valid`.
  - `sdata` bits 0,1,0,1,0,0,1,0,1,1, 16 cycles each, starting the cycle after the handshake.
  - `tx_done` pulses once at E0+160+1.
  - `ready` is low for 160 cycles.
- Back-to-back: `valid` held high with 8'h00 then 8'hFF.
  - The second start bit begins exactly 17 high cycles after the first stop bit begins.
  - Two `tx_done` pulses.
  - `datain` changes during the first frame do not alter the transmitted bits.
- Reset mid-frame: assert `reset` during data bit 3 of 8'h3C.
  - `sdata` = 1 on the next edge and stays high.
  - No `tx_done` pulse.
  - `ready` = 1 the cycle after `reset` drops, and a new byte 8'h81 transmits correctly.
- STOPBITS=2, DIV=16, byte 8'h01: the stop interval is 32 cycles high, and `tx_done` comes at E0+176+1.
- `UART_TX_PARITY_EN` defined, DIV=16:
  - Byte 8'h07 gives parity bit 1 in the 10th bit slot.
  - Byte 8'h03 gives parity bit 0.
  - Frame length is 176 cycles.
- Loopback: drive `sdata` into the UART receiver with matching parameters (parity undefined) and send 8'h55, 8'hC3, 8'h00, 8'hFF. The receiver's `dataout` must match each byte.
